filtro_iir_biquad_secuencial: RTL and testbench
===============================================

Name: filtro_iir_biquad_secuencial

Overview:
- Second-order recursive (biquad, direct form I) low-pass section.
- Consumes the five 23-bit coefficients produced by the coefficient selector muxes (b0, b1, b2, a1, a2).
- Computes one output sample per accepted input using a single shared multiplier over five MAC cycles.
- Sits between the sample-acquisition stage and the output/DAC formatting stage of the recursive filter.

Parameters:
- width, 23, sample and coefficient width; signed two's complement.
- frac, 14, fractional bits of the coefficient format (Q8.14).
- acc_width, 48, accumulator width; must be at least 2*width+2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- muestra_valida  input  1  one-cycle pulse requesting processing of x_in.
- x_in  input  width  input sample, signed Q(width-1).0.
- coef_b0, coef_b1, coef_b2  input  width each  feed-forward coefficients, signed Q8.14.
- coef_a1, coef_a2  input  width each  feedback coefficients, signed Q8.14.
- limpiar  input  1  synchronous clear of filter history.
- y_out  output  width  filtered sample, signed, registered.
- y_valida  output  1  one-cycle pulse when y_out is updated.
- ocupado  output  1  high while a sample is in progress.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low.
- While rst_n=0, the following are all 0:
  - state=IDLE, step counter, accumulator, latched coefficients;
  - history registers x1, x2, y1, y2;
  - outputs y_out, y_valida, ocupado.
- Equation: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2].
- FSM states: IDLE, MAC, FIN.
- IDLE:
  - On edge with muestra_valida=1: latch x_in and all five coefficients into internal registers, clear accumulator, step=0, go to MAC, ocupado=1.
  - Coefficients must not change effect mid-computation; the latched copies are used throughout.
- MAC, one term per cycle, step 0..4. Terms in order:
  - 0: +b0*x
  - 1: +b1*x1
  - 2: +b2*x2
  - 3: -a1*y1
  - 4: -a2*y2
- MAC arithmetic: full signed product (2*width bits), sign-extended into the acc_width accumulator. After step 4, go to FIN.
- FIN:
  - r = accumulator arithmetic-shifted right by frac (truncation toward minus infinity).
  - Saturate r to [-2^(width-1), 2^(width-1)-1] and register it into y_out.
  - Update history: x2<=x1, x1<=x, y2<=y1, y1<=saturated y.
  - Assert y_valida for exactly one cycle; ocupado=0; return to IDLE.
- Latency: start accepted at edge k -> y_out and y_valida visible after edge k+6. Throughput: one sample per 7 cycles minimum.
- muestra_valida while ocupado=1 is ignored. No queuing, no error flag.
- muestra_valida in the same cycle FIN completes is also ignored; it is accepted only when the state is IDLE.
- limpiar:
  - When IDLE: zeroes x1, x2, y1, y2 next edge; y_out is unchanged.
  - When busy: ignored.
  - If limpiar and muestra_valida are both high in IDLE, the clear takes priority and the sample is dropped.
- Reset asserted mid-computation: immediate abort to the reset values above. No partial history update.
- Accumulator sizing: worst case is 5 products of (-2^22)*(-2^22). 48 bits holds this without internal overflow; no wrap allowed.

Test Plan:
- Passthrough: b0=16384 (1.0), others 0; x_in=1000, then -1000 -> y_out=1000, then -1000; y_valida pulses exactly 6 cycles after each accepted start.
- Recursion: b0=16384, a1=-8192 (-0.5), others 0; impulse x=16384, then x=0, x=0 -> y = 16384, 8192, 4096.
- Saturation: b0=32768 (2.0), x=4194303 -> y_out=4194303; x=-4194304 -> y_out=-4194304.
- Busy/overlap:
  - Pulse muestra_valida at edges k and k+3 -> only one result; ocupado high k+1..k+6.
  - Coefficient change at k+2 does not alter the result.
- Clear: after the recursion test, pulse limpiar in IDLE, then impulse 16384 -> y sequence restarts at 16384, 8192.
- Reset mid-op: deassert rst_n at step 2 -> all outputs 0 immediately. After release, passthrough of x=500 yields 500 with no leftover history.

Source files
------------

// File: rtl/filtro_iir_biquad_secuencial.sv
// Direct-form-I biquad section that computes one output per accepted sample.
// A single shared signed multiplier performs five MAC steps on latched coefficients.
module filtro_iir_biquad_secuencial #(
  parameter int width     = 23,
  parameter int frac      = 14,
  parameter int acc_width = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    muestra_valida,
  input  logic signed [width-1:0] x_in,
  input  logic signed [width-1:0] coef_b0,
  input  logic signed [width-1:0] coef_b1,
  input  logic signed [width-1:0] coef_b2,
  input  logic signed [width-1:0] coef_a1,
  input  logic signed [width-1:0] coef_a2,
  input  logic                    limpiar,
  output logic signed [width-1:0] y_out,
  output logic                    y_valida,
  output logic                    ocupado
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, FIN = 2'd2} estado_t;

  localparam logic signed [acc_width-1:0] lim_max_c = {{(acc_width-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] lim_min_c = {{(acc_width-width+1){1'b1}}, {(width-1){1'b0}}};

  function automatic logic signed [width-1:0] saturar(input logic signed [acc_width-1:0] v);
    logic signed [width-1:0] r;
    if (v > lim_max_c) begin
      r = lim_max_c[width-1:0];
    end else if (v < lim_min_c) begin
      r = lim_min_c[width-1:0];
    end else begin
      r = v[width-1:0];
    end
    return r;
  endfunction

  estado_t estado_r, estado_s;
  logic [2:0] paso_r;
  logic signed [acc_width-1:0] acc_r, acc_s, termino_s, desplazado_s;
  logic signed [width-1:0] x_r, x1_r, x2_r, y1_r, y2_r;
  logic signed [width-1:0] b0_r, b1_r, b2_r, a1_r, a2_r;
  logic signed [width-1:0] coef_s, dato_s, y_sat_s, y_out_r;
  logic signed [2*width-1:0] coef_ext_s, dato_ext_s, producto_s;
  logic restar_s, y_valida_r, ocupado_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= IDLE;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Next-state logic; a clear in IDLE wins over a new sample
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      IDLE: begin
        if (muestra_valida && !limpiar) begin
          estado_s = MAC;
        end else begin
          estado_s = IDLE;
        end
      end
      MAC: begin
        if (paso_r == 3'd4) begin
          estado_s = FIN;
        end else begin
          estado_s = MAC;
        end
      end
      FIN:     estado_s = IDLE;
      default: estado_s = IDLE;
    endcase
  end

  // Operand selection for the current MAC term; feedback terms are subtracted
  always_comb begin
    coef_s   = '0;
    dato_s   = '0;
    restar_s = 1'b0;
    case (paso_r)
      3'd0: begin coef_s = b0_r; dato_s = x_r;  end
      3'd1: begin coef_s = b1_r; dato_s = x1_r; end
      3'd2: begin coef_s = b2_r; dato_s = x2_r; end
      3'd3: begin coef_s = a1_r; dato_s = y1_r; restar_s = 1'b1; end
      3'd4: begin coef_s = a2_r; dato_s = y2_r; restar_s = 1'b1; end
      default: begin coef_s = '0; dato_s = '0; restar_s = 1'b0; end
    endcase
  end

  // Full-precision product sign-extended into the accumulator, plus output scaling
  always_comb begin
    coef_ext_s   = {{width{coef_s[width-1]}}, coef_s};
    dato_ext_s   = {{width{dato_s[width-1]}}, dato_s};
    producto_s   = coef_ext_s * dato_ext_s;
    termino_s    = {{(acc_width-2*width){producto_s[2*width-1]}}, producto_s};
    if (restar_s) begin
      acc_s = acc_r - termino_s;
    end else begin
      acc_s = acc_r + termino_s;
    end
    desplazado_s = acc_r >>> frac;
    y_sat_s      = saturar(desplazado_s);
  end

  // Datapath, history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paso_r <= 3'd0;  acc_r <= '0;
      x_r <= '0;  x1_r <= '0; x2_r <= '0; y1_r <= '0; y2_r <= '0;
      b0_r <= '0; b1_r <= '0; b2_r <= '0; a1_r <= '0; a2_r <= '0;
      y_out_r <= '0; y_valida_r <= 1'b0; ocupado_r <= 1'b0;
    end else begin
      y_valida_r <= 1'b0;
      case (estado_r)
        IDLE: begin
          if (limpiar) begin
            x1_r <= '0; x2_r <= '0; y1_r <= '0; y2_r <= '0;
          end else if (muestra_valida) begin
            x_r  <= x_in;
            b0_r <= coef_b0; b1_r <= coef_b1; b2_r <= coef_b2;
            a1_r <= coef_a1; a2_r <= coef_a2;
            acc_r     <= '0;
            paso_r    <= 3'd0;
            ocupado_r <= 1'b1;
          end else begin
            ocupado_r <= 1'b0;
          end
        end
        MAC: begin
          acc_r  <= acc_s;
          paso_r <= paso_r + 3'd1;
        end
        FIN: begin
          y_out_r    <= y_sat_s;
          x2_r       <= x1_r;
          x1_r       <= x_r;
          y2_r       <= y1_r;
          y1_r       <= y_sat_s;
          y_valida_r <= 1'b1;
          ocupado_r  <= 1'b0;
          paso_r     <= 3'd0;
        end
        default: begin
          ocupado_r <= 1'b0;
          paso_r    <= 3'd0;
        end
      endcase
    end
  end

  assign y_out    = y_out_r;
  assign y_valida = y_valida_r;
  assign ocupado  = ocupado_r;

endmodule

// File: tb/tb_filtro_iir_biquad_secuencial.sv
// Self-checking bench for the sequential biquad against a plain-arithmetic difference-equation model.
module tb_filtro_iir_biquad_secuencial;

  logic clk = 1'b0;
  logic rst_n, muestra_valida, limpiar;
  logic signed [22:0] x_in, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic signed [22:0] y_out;
  logic y_valida, ocupado;

  int total = 0;
  int pases = 0;
  longint mx1, mx2, my1, my2;

  filtro_iir_biquad_secuencial dut (
    .clk(clk), .rst_n(rst_n), .muestra_valida(muestra_valida), .x_in(x_in),
    .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
    .coef_a1(coef_a1), .coef_a2(coef_a2), .limpiar(limpiar),
    .y_out(y_out), .y_valida(y_valida), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic chequear(input string tag, input longint obs, input longint esp);
    total++;
    if (obs == esp) begin
      pases++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 64'sd4194303) return 64'sd4194303;
    else if (v < -64'sd4194304) return -64'sd4194304;
    else return v;
  endfunction

  // Expected output from the difference equation with floor scaling by 2^14
  function automatic longint esperado(input longint x);
    longint acc;
    acc = longint'(coef_b0) * x + longint'(coef_b1) * mx1 + longint'(coef_b2) * mx2
        - longint'(coef_a1) * my1 - longint'(coef_a2) * my2;
    return sat(acc >>> 14);
  endfunction

  task automatic borrar_modelo();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  task automatic coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
    coef_b0 = 23'(b0); coef_b1 = 23'(b1); coef_b2 = 23'(b2);
    coef_a1 = 23'(a1); coef_a2 = 23'(a2);
  endtask

  task automatic muestra(input logic signed [22:0] x, input string tag);
    longint esp;
    int n;
    esp = esperado(longint'(x));
    x_in = x; muestra_valida = 1'b1;
    @(posedge clk); #1; muestra_valida = 1'b0;
    chequear({tag, "_ocupado_ini"}, longint'(ocupado), 1);
    n = 0;
    while (!y_valida && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chequear({tag, "_latencia"}, n, 6);
    chequear({tag, "_y"}, longint'(y_out), esp);
    chequear({tag, "_ocupado_fin"}, longint'(ocupado), 0);
    mx2 = mx1; mx1 = longint'(x); my2 = my1; my1 = esp;
    @(posedge clk); #1;
    chequear({tag, "_pulso_unico"}, longint'(y_valida), 0);
  endtask

  task automatic pulso_limpiar(input logic con_muestra);
    longint y_prev;
    y_prev = longint'(y_out);
    limpiar = 1'b1; muestra_valida = con_muestra; x_in = 23'sd777;
    @(posedge clk); #1; limpiar = 1'b0; muestra_valida = 1'b0;
    chequear("limpiar_ocupado", longint'(ocupado), 0);
    chequear("limpiar_y_igual", longint'(y_out), y_prev);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (y_valida) chequear("limpiar_sin_resultado", 1, 0);
    end
    borrar_modelo();
  endtask

  initial begin
    int pulsos, ciclo_pulso;
    longint y_pulso, esp;
    rst_n = 1'b0; muestra_valida = 1'b0; limpiar = 1'b0; x_in = '0;
    coefs(0, 0, 0, 0, 0);
    borrar_modelo();
    #12;
    chequear("reset_y", longint'(y_out), 0);
    chequear("reset_valida", longint'(y_valida), 0);
    chequear("reset_ocupado", longint'(ocupado), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Passthrough
    coefs(16384, 0, 0, 0, 0);
    muestra(23'sd1000, "paso1");
    chequear("paso1_lit", longint'(y_out), 1000);
    muestra(-23'sd1000, "paso2");
    chequear("paso2_lit", longint'(y_out), -1000);

    // Recursion from clean history
    coefs(16384, 0, 0, -8192, 0);
    pulso_limpiar(1'b0);
    muestra(23'sd16384, "rec0");
    chequear("rec0_lit", longint'(y_out), 16384);
    muestra(23'sd0, "rec1");
    chequear("rec1_lit", longint'(y_out), 8192);
    muestra(23'sd0, "rec2");
    chequear("rec2_lit", longint'(y_out), 4096);

    // Clear with a simultaneous sample: sample dropped, then impulse restarts
    pulso_limpiar(1'b1);
    muestra(23'sd16384, "clr0");
    chequear("clr0_lit", longint'(y_out), 16384);
    muestra(23'sd0, "clr1");
    chequear("clr1_lit", longint'(y_out), 8192);

    // Saturation
    coefs(32768, 0, 0, 0, 0);
    muestra(23'sd4194303, "satp");
    chequear("satp_lit", longint'(y_out), 4194303);
    muestra(-23'sd4194304, "satn");
    chequear("satn_lit", longint'(y_out), -4194304);

    // Overlapping request and mid-computation coefficient change
    coefs(16384, 8192, 0, 0, 0);
    esp = esperado(longint'(23'sd3000));
    x_in = 23'sd3000; muestra_valida = 1'b1;
    @(posedge clk); #1; muestra_valida = 1'b0;
    pulsos = 0; ciclo_pulso = -1; y_pulso = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 1) begin coef_b0 = 23'sd5000; coef_b1 = -23'sd100; x_in = 23'sd9; end
      if (c == 2) muestra_valida = 1'b1;
      if (c == 3) muestra_valida = 1'b0;
      chequear($sformatf("solape_ocupado_%0d", c), longint'(ocupado), (c <= 5) ? 1 : 0);
      if (y_valida) begin pulsos++; ciclo_pulso = c; y_pulso = longint'(y_out); end
      @(posedge clk); #1;
    end
    chequear("solape_pulsos", pulsos, 1);
    chequear("solape_ciclo", ciclo_pulso, 6);
    chequear("solape_y", y_pulso, esp);
    mx2 = mx1; mx1 = 3000; my2 = my1; my1 = esp;

    // Randomized coefficients and samples
    for (int i = 0; i < 20; i++) begin
      coefs(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      muestra(23'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a computation
    coefs(16384, 0, 0, -8192, 0);
    x_in = 23'sd1234; muestra_valida = 1'b1;
    @(posedge clk); #1; muestra_valida = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chequear("rst_mid_y", longint'(y_out), 0);
    chequear("rst_mid_valida", longint'(y_valida), 0);
    chequear("rst_mid_ocupado", longint'(ocupado), 0);
    borrar_modelo();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    muestra(23'sd500, "post_rst");
    chequear("post_rst_lit", longint'(y_out), 500);

    $display("%0d/%0d checks passed", pases, total);
    $finish;
  end

endmodule
